nap_read_arbiter: RTL
=====================

Name: nap_read_arbiter

Overview:
- Shares the read channels (AR/R) of one AXI initiator NAP between NUM_REQ local requesters.
- Round-robin arbitration on AR; requester index is tagged into ARID; R beats are routed back by RID.
- Per-requester outstanding-burst counters provide flow control and error detection.
- Sits between datapath read engines and the NAP initiator wrapper's t_AXI4 read signals. Write channels are out of scope.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); IDX_W = clog2(NUM_REQ).
- ADDR_WIDTH, 42, AXI address width.
- DATA_WIDTH, 256, AXI data width; arsize = clog2(DATA_WIDTH/8).
- ID_WIDTH, 8, NAP ARID/RID width.
- MAX_OUTSTANDING, 8, maximum in-flight bursts per requester; CNT_W = clog2(MAX_OUTSTANDING+1).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset, asynchronous, active-high
- i_req_arvalid  in  NUM_REQ  per-requester read request
- o_req_arready  out  NUM_REQ  per-requester accept pulse
- i_req_araddr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- i_req_arlen  in  NUM_REQ*8  packed burst lengths (beats-1)
- o_req_rvalid  out  NUM_REQ  per-requester read data valid
- i_req_rready  in  NUM_REQ  per-requester read data ready
- o_req_rdata  out  DATA_WIDTH  read data, broadcast to all requesters
- o_req_rresp  out  2  read response, broadcast
- o_req_rlast  out  1  last beat, broadcast
- o_nap_arvalid  out  1  NAP AR valid
- i_nap_arready  in  1  NAP AR ready
- o_nap_araddr  out  ADDR_WIDTH  NAP AR address
- o_nap_arlen  out  8  NAP AR burst length
- o_nap_arid  out  ID_WIDTH  NAP AR ID
- o_nap_arsize  out  3  constant clog2(DATA_WIDTH/8)
- o_nap_arburst  out  2  constant 2'b01 (INCR)
- o_nap_arqos  out  4  constant 0
- i_nap_rvalid  in  1  NAP R valid
- o_nap_rready  out  1  NAP R ready
- i_nap_rdata  in  DATA_WIDTH  NAP R data
- i_nap_rresp  in  2  NAP R response
- i_nap_rid  in  ID_WIDTH  NAP R ID
- i_nap_rlast  in  1  NAP R last
- o_outstanding  out  NUM_REQ*CNT_W  per-requester in-flight burst count
- o_err_rid  out  1  sticky error flag: unexpected RID received

Behaviour:
- Reset (asynchronous): state=IDLE, rr_ptr=0, all counters 0, o_nap_arvalid=0, o_req_arready=0, o_nap_araddr/arlen/arid=0, o_err_rid=0. Reset mid-burst abandons in-flight bursts; the NAP is reset by the same domain.
- A requester k is eligible when i_req_arvalid[k]=1 and outstanding[k] < MAX_OUTSTANDING.
- AR FSM, IDLE:
  - If any requester is eligible, grant the first eligible index searching from rr_ptr upward with wrap.
  - Pulse o_req_arready[grant]=1 for exactly that cycle.
  - Register addr/len into the NAP AR registers; o_nap_arid = zero-extended grant index; set o_nap_arvalid=1; go to ISSUE.
- AR FSM, ISSUE:
  - Hold all AR outputs stable while i_nap_arready=0.
  - On i_nap_arready=1: increment outstanding[grant], set rr_ptr = (grant+1) mod NUM_REQ, o_nap_arvalid=0, return to IDLE.
- AR throughput: at most one AR per 2 cycles. Latency from arvalid to o_nap_arvalid is 1 cycle when no other requester is competing.
- R path is combinational, zero-latency. Let idx = i_nap_rid[IDX_W-1:0].
  - A beat is valid-routed when upper RID bits = 0, idx < NUM_REQ, and outstanding[idx] > 0.
  - For a valid-routed beat: o_req_rvalid[idx] = i_nap_rvalid, other o_req_rvalid bits = 0, o_nap_rready = i_req_rready[idx].
  - Otherwise (unexpected RID): o_req_rvalid = 0, o_nap_rready = 1 so the beat is sunk; o_err_rid is set on that handshake and holds until reset.
  - o_req_rdata/rresp/rlast = i_nap_rdata/rresp/rlast, unconditionally.
- Counters:
  - A valid-routed handshake (i_nap_rvalid & o_nap_rready) with i_nap_rlast=1 decrements outstanding[idx].
  - If the increment and decrement hit the same counter in the same cycle, the counter is unchanged.
  - Eligibility gating prevents overflow; the valid-routed check prevents underflow.
- Non-zero rresp is passed through; it does not set an error.

Test Plan:
- Single requester: req 1, addr 0x1000, len 3; NAP arready=1 → o_nap_arvalid rises 1 cycle later with arid=1, arlen=3, arsize=5, arburst=01; 4 R beats with rid=1 reach only o_req_rvalid[1]; o_outstanding[1] goes 0→1→0.
- Fairness: all 4 requesters hold arvalid continuously, arready=1 → grant order 0,1,2,3,0,1… with one AR every 2 cycles.
- Backpressure: arready held 0 for 5 cycles → araddr/arlen/arid stable throughout; no second o_req_arready pulse in that window.
- Outstanding limit: MAX_OUTSTANDING=8, req 2 issues 8 ARs with no R returned → 9th request not granted; one rlast beat on rid=2 → 9th grant occurs in the next IDLE cycle.
- Simultaneous events: AR handshake for req 0 in the same cycle as the rlast for rid=0 with outstanding[0]=3 → counter stays 3. Separately, rid=2 beat with i_req_rready[2]=0 → o_nap_rready=0.
- Unexpected RID: rid=0x05 with NUM_REQ=4, or rid=0 with outstanding[0]=0 → beat sunk (o_nap_rready=1), no o_req_rvalid, o_err_rid=1 held until i_reset.

Source files
------------

// File: rtl/nap_read_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nap_read_arbiter: shares one NAP AXI read port between NUM_REQ requesters |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module nap_read_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_WIDTH      = 42,
  parameter int DATA_WIDTH      = 256,
  parameter int ID_WIDTH        = 8,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                          i_clk,
  input  logic                                          i_reset,
  input  logic [NUM_REQ-1:0]                            i_req_arvalid,
  output logic [NUM_REQ-1:0]                            o_req_arready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]                 i_req_araddr,
  input  logic [NUM_REQ*8-1:0]                          i_req_arlen,
  output logic [NUM_REQ-1:0]                            o_req_rvalid,
  input  logic [NUM_REQ-1:0]                            i_req_rready,
  output logic [DATA_WIDTH-1:0]                         o_req_rdata,
  output logic [1:0]                                    o_req_rresp,
  output logic                                          o_req_rlast,
  output logic                                          o_nap_arvalid,
  input  logic                                          i_nap_arready,
  output logic [ADDR_WIDTH-1:0]                         o_nap_araddr,
  output logic [7:0]                                    o_nap_arlen,
  output logic [ID_WIDTH-1:0]                           o_nap_arid,
  output logic [2:0]                                    o_nap_arsize,
  output logic [1:0]                                    o_nap_arburst,
  output logic [3:0]                                    o_nap_arqos,
  input  logic                                          i_nap_rvalid,
  output logic                                          o_nap_rready,
  input  logic [DATA_WIDTH-1:0]                         i_nap_rdata,
  input  logic [1:0]                                    i_nap_rresp,
  input  logic [ID_WIDTH-1:0]                           i_nap_rid,
  input  logic                                          i_nap_rlast,
  output logic [NUM_REQ*$clog2(MAX_OUTSTANDING+1)-1:0]  o_outstanding,
  output logic                                          o_err_rid
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);
  localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q [NUM_REQ];
  logic [CNT_W-1:0]      cnt_d [NUM_REQ];

  logic [NUM_REQ-1:0]    w_eligible;
  logic [NUM_REQ-1:0]    w_req_arready;
  logic [NUM_REQ-1:0]    w_inc;
  logic [NUM_REQ-1:0]    w_dec;
  logic [NUM_REQ-1:0]    w_req_rvalid;
  logic                  w_found_hi, w_found_lo;
  logic [IDX_W-1:0]      w_pick_hi, w_pick_lo, w_pick;
  logic                  w_routed;
  logic [IDX_W-1:0]      w_sel;
  logic                  w_nap_rready;

  always_comb begin
    for (int j = 0; j < NUM_REQ; j++) begin
      w_eligible[j] = i_req_arvalid[j] && (cnt_q[j] < C_MAX_CNT);
    end
  end

  // Round-robin: first eligible at or above rr_ptr, else wrap to the lowest.
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_pick_hi  = '0;
    w_pick_lo  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_found_hi && w_eligible[j] && (IDX_W'(j) >= rr_ptr_q)) begin
        w_found_hi = 1'b1;
        w_pick_hi  = IDX_W'(j);
      end
      if (!w_found_lo && w_eligible[j]) begin
        w_found_lo = 1'b1;
        w_pick_lo  = IDX_W'(j);
      end
    end
    w_pick = w_found_hi ? w_pick_hi : w_pick_lo;
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    araddr_d      = araddr_q;
    arlen_d       = arlen_q;
    arid_d        = arid_q;
    arvalid_d     = arvalid_q;
    w_req_arready = '0;
    w_inc         = '0;
    case (state_q)
      ST_IDLE: begin
        if (w_found_lo) begin
          for (int j = 0; j < NUM_REQ; j++) begin
            if (IDX_W'(j) == w_pick) begin
              w_req_arready[j] = 1'b1;
              araddr_d         = i_req_araddr[j*ADDR_WIDTH +: ADDR_WIDTH];
              arlen_d          = i_req_arlen[j*8 +: 8];
            end
          end
          grant_d   = w_pick;
          arid_d    = ID_WIDTH'(w_pick);
          arvalid_d = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (i_nap_arready) begin
          for (int j = 0; j < NUM_REQ; j++) begin
            if (IDX_W'(j) == grant_q) w_inc[j] = 1'b1;
          end
          rr_ptr_d  = (grant_q == IDX_W'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;
          arvalid_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // An RID only routes if it names a requester that actually has a burst in flight.
  always_comb begin
    w_routed = 1'b0;
    w_sel    = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if ((i_nap_rid == ID_WIDTH'(j)) && (cnt_q[j] != '0)) begin
        w_routed = 1'b1;
        w_sel    = IDX_W'(j);
      end
    end
    w_req_rvalid = '0;
    w_nap_rready = 1'b1;
    w_dec        = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_routed && (w_sel == IDX_W'(j))) begin
        w_req_rvalid[j] = i_nap_rvalid;
        w_nap_rready    = i_req_rready[j];
        w_dec[j]        = i_nap_rvalid && i_req_rready[j] && i_nap_rlast;
      end
    end
    err_d = err_q | (i_nap_rvalid & ~w_routed);
  end

  always_comb begin
    for (int j = 0; j < NUM_REQ; j++) begin
      cnt_d[j] = cnt_q[j];
      if (w_inc[j] && !w_dec[j]) begin
        cnt_d[j] = cnt_q[j] + 1'b1;
      end else if (w_dec[j] && !w_inc[j]) begin
        cnt_d[j] = cnt_q[j] - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arid_q    <= '0;
      arvalid_q <= 1'b0;
      err_q     <= 1'b0;
      for (int j = 0; j < NUM_REQ; j++) cnt_q[j] <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arid_q    <= arid_d;
      arvalid_q <= arvalid_d;
      err_q     <= err_d;
      for (int j = 0; j < NUM_REQ; j++) cnt_q[j] <= cnt_d[j];
    end
  end

  generate
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_out_cnt
      assign o_outstanding[k*CNT_W +: CNT_W] = cnt_q[k];
    end
  endgenerate

  assign o_req_arready = w_req_arready;
  assign o_nap_arvalid = arvalid_q;
  assign o_nap_araddr  = araddr_q;
  assign o_nap_arlen   = arlen_q;
  assign o_nap_arid    = arid_q;
  assign o_nap_arsize  = 3'($clog2(DATA_WIDTH/8));
  assign o_nap_arburst = 2'b01;
  assign o_nap_arqos   = 4'd0;
  assign o_req_rvalid  = w_req_rvalid;
  assign o_nap_rready  = w_nap_rready;
  assign o_req_rdata   = i_nap_rdata;
  assign o_req_rresp   = i_nap_rresp;
  assign o_req_rlast   = i_nap_rlast;
  assign o_err_rid     = err_q;

endmodule
`default_nettype wire
